mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised load/store unit that replaces the fixed MAR/MDR/write-data registers and load-extension mux of the RV32I multicycle datapath. It accepts one memory request at a time from the control FSM, generates an aligned address, byte enables and lane-shifted write data, runs a read/write handshake with memory, and returns sign- or zero-extended load data. It also flags misaligned, illegal and timed-out accesses. It is generalised to XLEN = 32 or 64.

## Interface
- XLEN, 32, data/address width; legal values are 32 and 64.
- TIMEOUT_CYCLES, 0, maximum ACCESS cycles before abort; 0 disables the timeout.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-low, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_misaligned, resp_illegal, resp_timeout  out  1 each  error flags; valid only with resp_valid.
- mem_address  out  XLEN  request address with the low log2(XLEN/8) bits cleared.
- mem_read, mem_write  out  1 each  memory strobes.
- mem_byte_enable  out  XLEN/8  write lane mask.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rdata  in  XLEN  read data.
- mem_resp  in  1  memory completion.

## Operation
- Notation: OFF = req_addr[log2(XLEN/8)-1:0]. SIZE is set by funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 8 bytes.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; plus 011 LD and 110 LWU when XLEN = 64.
  - Stores: 000, 001, 010; plus 011 when XLEN = 64.
  - Every other code is illegal.
- On acceptance the unit captures store, funct3, address and data into internal registers. Request inputs are don't-care afterwards.
- FSM states:
  - IDLE: req_ready = 1. When req_valid is high, capture the request.
    - Illegal funct3 → ERR with illegal = 1.
    - Else OFF mod SIZE ≠ 0 → ERR with misaligned = 1.
    - Else → ACCESS.
    - Illegal takes priority over misaligned.
  - ACCESS: mem_read = !store, mem_write = store. The strobe stays high every cycle until mem_resp.
    - When mem_resp is high, load mem_rdata into the data register → DONE.
    - If TIMEOUT_CYCLES > 0 and TIMEOUT_CYCLES cycles elapse without mem_resp → ERR with timeout = 1. The strobe drops at that edge.
  - DONE: resp_valid = 1 → IDLE.
  - ERR: resp_valid = 1 with the recorded flag, resp_rdata = 0 → IDLE. No memory strobe is ever issued for a misaligned or illegal access.
- Stores:
  - mem_byte_enable = ((1 << SIZE) − 1) << OFF.
  - mem_wdata = req_wdata << (8·OFF).
  - Both are held constant through ACCESS.
- Loads:
  - lane = data_reg >> (8·OFF), then truncate to SIZE bytes.
  - Sign-extend when funct3[2] = 0, zero-extend when funct3[2] = 1.
  - For XLEN = 32, LW passes through unchanged.
- mem_address, mem_byte_enable and mem_wdata are registered. They hold their last value outside ACCESS, and mem_byte_enable is 0 for loads.
- resp_rdata is 0 for stores.

## Timing
- Reset (rst = 0 at an edge):
  - state = IDLE; mem_read = mem_write = resp_valid = 0.
  - All flags 0, mem_address = 0, mem_byte_enable = 0, mem_wdata = 0, resp_rdata = 0, timeout counter = 0.
  - req_ready is 1 after the reset edge.
- Reset mid-ACCESS: the strobes drop at that edge. A late mem_resp arriving in IDLE is ignored.
- Latency (request accepted at edge E0):
  - Strobes are high in cycle 1.
  - If mem_resp is high in cycle k, resp_valid is high in cycle k+1.
  - Minimum 2 cycles from acceptance to response. Error responses take exactly 1 cycle (the cycle after E0).
- req_ready is low from the acceptance edge until the edge that ends DONE/ERR. Back-to-back requests are therefore spaced by at least 3 cycles for memory accesses and 2 for errors.
- The timeout counter clears on entry to ACCESS and increments on each ACCESS cycle without mem_resp. If mem_resp and timeout expiry occur in the same cycle, mem_resp wins.
- resp_valid is exactly one cycle wide. There is no backpressure on the response.

## Test plan
- XLEN = 32, load LB at 0x1003, mem_rdata = 0x80FF_0000, mem_resp in the first ACCESS cycle → resp_rdata = 0xFFFF_FF80, resp_valid 2 cycles after acceptance.
- LHU at 0x2002 with mem_rdata = 0xBEEF_1234 → 0x0000_BEEF. The same access as LH → 0xFFFF_BEEF. mem_address = 0x2000.
- SB at 0x3001 with req_wdata = 0x0000_00AB → mem_byte_enable = 0b0010, mem_wdata = 0x0000_AB00, mem_write held for 5 cycles until mem_resp.
- Misaligned cases:
  - LW at 0x4002 → resp_misaligned = 1 one cycle after acceptance, mem_read never asserted.
  - funct3 = 111 → resp_illegal = 1.
  - XLEN = 32 with LD → resp_illegal = 1.
- TIMEOUT_CYCLES = 4, no mem_resp → mem_read high for 4 cycles, then resp_timeout = 1. A later mem_resp is ignored.
- XLEN = 64, LWU at 0x…04 with mem_rdata = 0x8000_0001_xxxx_xxxx → 0x0000_0000_8000_0001. Asserting rst = 0 mid-ACCESS → IDLE, strobes low on the next edge.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: takes one request at a time, presents an aligned
// address with lane-shifted store data and byte enables, runs a memory
// read/write handshake and returns extended load data with error flags.
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_misaligned_o,
  output logic              resp_illegal_o,
  output logic              resp_timeout_o,
  output logic [XLEN-1:0]   mem_address_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [XLEN/8-1:0] mem_byte_enable_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_resp_i
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_e;

  state_e          state_q;
  logic            ready_q, store_q, mem_read_q, mem_write_q;
  logic [2:0]      f3_q;
  logic [OW-1:0]   off_q;
  logic [TW-1:0]   tcnt_q;
  logic            resp_valid_q, mis_q, ill_q, tmo_q;
  logic [XLEN-1:0] resp_rdata_q, addr_q, wdata_q;
  logic [NB-1:0]   be_q;

  logic            req_illegal, req_misaligned;
  logic [2:0]      req_off3, size_m1;
  logic [7:0]      be_base;
  logic [NB-1:0]   be_shift;
  logic [XLEN-1:0] wdata_shift, lane, ld_ext;

  assign req_off3    = 3'(req_addr_i[OW-1:0]);
  assign be_shift    = NB'(be_base) << req_addr_i[OW-1:0];
  assign wdata_shift = req_wdata_i << {req_addr_i[OW-1:0], 3'b000};
  assign lane        = mem_rdata_i >> {off_q, 3'b000};

  // Decode legality, alignment and the unshifted lane mask of the incoming request.
  always_comb begin
    req_illegal = 1'b1;
    size_m1     = 3'b000;
    be_base     = 8'h01;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b011:                 req_illegal = (XLEN != 64);
      3'b100, 3'b101:         req_illegal = req_store_i;
      3'b110:                 req_illegal = req_store_i || (XLEN != 64);
      default:                req_illegal = 1'b1;
    endcase
    case (req_funct3_i[1:0])
      2'b00:   begin size_m1 = 3'b000; be_base = 8'h01; end
      2'b01:   begin size_m1 = 3'b001; be_base = 8'h03; end
      2'b10:   begin size_m1 = 3'b011; be_base = 8'h0F; end
      default: begin size_m1 = 3'b111; be_base = 8'hFF; end
    endcase
    req_misaligned = |(req_off3 & size_m1);
  end

  // Pick the addressed lane out of the read word and sign/zero extend it.
  always_comb begin
    ld_ext = lane;
    case (f3_q)
      3'b000:  ld_ext = XLEN'($signed(lane[7:0]));
      3'b100:  ld_ext = XLEN'(lane[7:0]);
      3'b001:  ld_ext = XLEN'($signed(lane[15:0]));
      3'b101:  ld_ext = XLEN'(lane[15:0]);
      3'b010:  ld_ext = XLEN'($signed(lane[31:0]));
      3'b110:  ld_ext = XLEN'(lane[31:0]);
      default: ld_ext = lane;
    endcase
  end

  // Request FSM; every output is a register so the memory side sees clean strobes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      store_q      <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= '0;
      tcnt_q       <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mis_q        <= 1'b0;
      ill_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            ready_q <= 1'b0;
            store_q <= req_store_i;
            f3_q    <= req_funct3_i;
            off_q   <= req_addr_i[OW-1:0];
            addr_q  <= {req_addr_i[XLEN-1:OW], {OW{1'b0}}};
            be_q    <= req_store_i ? be_shift : '0;
            if (req_store_i) wdata_q <= wdata_shift;
            if (req_illegal) begin
              state_q      <= ERR;
              ill_q        <= 1'b1;
              resp_valid_q <= 1'b1;
            end else if (req_misaligned) begin
              state_q      <= ERR;
              mis_q        <= 1'b1;
              resp_valid_q <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              tcnt_q      <= '0;
              mem_read_q  <= !req_store_i;
              mem_write_q <= req_store_i;
            end
          end
        end
        ACCESS: begin
          // A response in the expiry cycle still completes the access.
          if (mem_resp_i) begin
            state_q      <= DONE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_rdata_q <= store_q ? '0 : ld_ext;
            resp_valid_q <= 1'b1;
          end else if (TIMEOUT_CYCLES > 0 && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= ERR;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            tmo_q        <= 1'b1;
            resp_valid_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: begin
          // DONE / ERR: single response cycle, then clear the response side.
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          mis_q        <= 1'b0;
          ill_q        <= 1'b0;
          tmo_q        <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o       = ready_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_rdata_o      = resp_rdata_q;
  assign resp_misaligned_o = mis_q;
  assign resp_illegal_o    = ill_q;
  assign resp_timeout_o    = tmo_q;
  assign mem_address_o     = addr_q;
  assign mem_read_o        = mem_read_q;
  assign mem_write_o       = mem_write_q;
  assign mem_byte_enable_o = be_q;
  assign mem_wdata_o       = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: an XLEN=32 instance without timeout and an
// XLEN=64 instance with TIMEOUT_CYCLES=4, each with a request driver, a
// memory responder and a response monitor fed by an expectation queue.
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] rdata;
    bit          mis, ill, tmo;
    longint      cyc;
  } exp_t;

  typedef struct {
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  be;
    bit          st;
    int          delay;
  } mem_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event", nm);
  endtask

  // Reference behaviour from the ISA rules, byte arithmetic on 64-bit values.
  function automatic void model(input int xl, input bit st, input logic [2:0] f3,
                                input logic [63:0] addr_in, input logic [63:0] wd,
                                input logic [63:0] rd, output bit ill, output bit mis,
                                output logic [63:0] rdx, output logic [63:0] aal,
                                output logic [7:0] be, output logic [63:0] wsh);
    logic [63:0] xmask, vmask, addr;
    int nb, off, size;
    xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    addr  = addr_in & xmask;
    nb    = xl / 8;
    off   = int'(addr % 64'(nb));
    size  = 1 << f3[1:0];
    if (st) ill = !(f3 <= 3'd2 || (xl == 64 && f3 == 3'd3));
    else    ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (xl == 64 && f3 inside {3'd3, 3'd6}));
    mis   = (off % size) != 0;
    aal   = addr - 64'(off);
    be    = st ? 8'(((1 << size) - 1) << off) : 8'h00;
    wsh   = (wd << (8 * off)) & xmask;
    vmask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    rdx   = ((rd & xmask) >> (8 * off)) & vmask;
    if (!f3[2] && rdx[8 * size - 1]) rdx = rdx | ~vmask;
    rdx   = st ? 64'h0 : (rdx & xmask);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int XL  = (g == 0) ? 32 : 64;
    localparam int TMO = (g == 0) ? 0 : 4;

    logic          rst, req_valid, req_ready, req_store, resp_valid;
    logic          rmis, rill, rtmo, mrd, mwr, mem_resp;
    logic [2:0]    req_f3;
    logic [XL-1:0] req_addr, req_wdata, resp_rdata, maddr, mwdata, mem_rdata;
    logic [XL/8-1:0] mbe;
    longint cyc   = 0;
    bit     done  = 0;
    bit     stray = 0;
    bit     act   = 0;
    int     cnt   = 0;
    mem_t   cur;
    exp_t   me;
    exp_t   expq[$];
    mem_t   memq[$];

    mem_access_unit #(.XLEN(XL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
      .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
      .resp_misaligned_o(rmis), .resp_illegal_o(rill), .resp_timeout_o(rtmo),
      .mem_address_o(maddr), .mem_read_o(mrd), .mem_write_o(mwr),
      .mem_byte_enable_o(mbe), .mem_wdata_o(mwdata),
      .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one request and queue what the response and memory side must look like.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input int dly);
      exp_t e;
      mem_t m;
      bit ill, mis;
      logic [63:0] rdx, aal, wsh;
      logic [7:0] be;
      int w = 0;
      int d = dly;
      if (TMO == 0 && d > 20) d = 9;
      while (!req_ready && w < 200) begin @(negedge clk); w++; end
      if (!req_ready) begin flag_fail($sformatf("x%0d.ready_wait", XL)); return; end
      model(XL, st, f3, a, wd, rd, ill, mis, rdx, aal, be, wsh);
      req_valid = 1'b1; req_store = st; req_f3 = f3;
      req_addr  = XL'(a); req_wdata = XL'(wd);
      @(posedge clk); #1;
      req_valid = 1'b0; req_store = 1'($urandom); req_f3 = 3'($urandom);
      req_addr  = XL'({$urandom, $urandom}); req_wdata = XL'({$urandom, $urandom});
      e.ill   = ill;
      e.mis   = !ill && mis;
      e.tmo   = !ill && !mis && TMO > 0 && d > TMO;
      e.rdata = (e.ill || e.mis || e.tmo) ? 64'h0 : rdx;
      e.cyc   = cyc + ((e.ill || e.mis) ? 0 : (e.tmo ? TMO : d));
      expq.push_back(e);
      if (!e.ill && !e.mis) begin
        m.addr = aal; m.wdata = wsh; m.rdata = rd; m.be = be; m.st = st; m.delay = d;
        memq.push_back(m);
      end
      @(negedge clk);
    endtask

    // Memory model: checks the strobed request every cycle, answers after the programmed delay.
    always @(negedge clk) begin
      mem_resp  = 1'b0;
      mem_rdata = XL'({$urandom, $urandom});
      if (!rst) begin
        act = 1'b0; memq.delete(); stray = 1'b1;
      end else if (mrd || mwr) begin
        if (!act) begin
          if (memq.size() == 0) flag_fail($sformatf("x%0d.unexpected_strobe", XL));
          else begin cur = memq.pop_front(); act = 1'b1; cnt = 0; end
        end
        if (act) begin
          cnt++;
          chk($sformatf("x%0d.strobes", XL), {62'h0, mrd, mwr}, {62'h0, !cur.st, cur.st});
          chk($sformatf("x%0d.mem_address", XL), 64'(maddr), cur.addr);
          chk($sformatf("x%0d.byte_enable", XL), 64'(mbe), 64'(cur.be));
          if (cur.st) chk($sformatf("x%0d.mem_wdata", XL), 64'(mwdata), cur.wdata);
          if (cnt == cur.delay) begin
            mem_resp = 1'b1; mem_rdata = XL'(cur.rdata); act = 1'b0;
          end
        end
      end else if (act) begin
        // Strobe fell without a response: must be a timeout of exactly TMO cycles.
        chk($sformatf("x%0d.timeout_len", XL), 64'(cnt), 64'(TMO));
        act = 1'b0;
        mem_resp = 1'b1;
      end else if (stray) begin
        mem_resp = 1'b1; stray = 1'b0;
      end
    end

    // Response monitor.
    always @(negedge clk) begin
      if (rst && resp_valid) begin
        if (expq.size() == 0) flag_fail($sformatf("x%0d.unexpected_resp", XL));
        else begin
          me = expq.pop_front();
          chk($sformatf("x%0d.resp_cycle", XL), 64'(cyc), 64'(me.cyc));
          chk($sformatf("x%0d.resp_rdata", XL), 64'(resp_rdata), me.rdata);
          chk($sformatf("x%0d.resp_flags", XL), {61'h0, rmis, rill, rtmo}, {61'h0, me.mis, me.ill, me.tmo});
          chk($sformatf("x%0d.ready_busy", XL), 64'(req_ready), 64'h0);
        end
      end
    end

    initial begin
      logic [63:0] a;
      logic [2:0]  f3;
      int w;
      rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_f3 = 3'h0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("x%0d.rst_ready", XL), 64'(req_ready), 64'h1);
      chk($sformatf("x%0d.rst_strobes", XL), {61'h0, mrd, mwr, resp_valid}, 64'h0);
      chk($sformatf("x%0d.rst_flags", XL), {61'h0, rmis, rill, rtmo}, 64'h0);
      chk($sformatf("x%0d.rst_addr", XL), 64'(maddr), 64'h0);
      chk($sformatf("x%0d.rst_be", XL), 64'(mbe), 64'h0);
      chk($sformatf("x%0d.rst_wdata", XL), 64'(mwdata), 64'h0);
      chk($sformatf("x%0d.rst_rdata", XL), 64'(resp_rdata), 64'h0);
      rst = 1'b1;

      issue(0, 3'b000, 64'h1003, 64'h0, 64'h80FF_0000, 1);                 // LB
      issue(0, 3'b101, 64'h2002, 64'h0, 64'hBEEF_1234, 2);                 // LHU
      issue(0, 3'b001, 64'h2002, 64'h0, 64'hBEEF_1234, 1);                 // LH
      issue(1, 3'b000, 64'h3001, 64'h0000_00AB, 64'h0, 5);                 // SB
      issue(0, 3'b010, 64'h4002, 64'h0, 64'h0, 1);                         // LW misaligned
      issue(0, 3'b111, 64'h4000, 64'h0, 64'h0, 1);                         // illegal
      issue(0, 3'b011, 64'h5000, 64'h0, 64'h1122_3344_5566_7788, 1);       // LD
      issue(0, 3'b010, 64'h6000, 64'h0, 64'h0, 100);                       // no response
      issue(0, 3'b110, 64'h7004, 64'h0, 64'h8000_0001_DEAD_BEEF, 2);       // LWU
      issue(1, 3'b011, 64'h8000, 64'h0123_4567_89AB_CDEF, 64'h0, 3);       // SD
      issue(1, 3'b010, 64'h9004, 64'hCAFE_F00D, 64'h0, 1);                 // SW
      issue(1, 3'b001, 64'h9006, 64'h1234, 64'h0, 2);                      // SH
      issue(1, 3'b100, 64'h9000, 64'h55, 64'h0, 1);                        // illegal store

      repeat (150) begin
        f3 = 3'($urandom);
        a  = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
        issue(1'($urandom), f3, a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 6));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      w = 0;
      while ((expq.size() != 0 || memq.size() != 0 || act) && w < 300) begin @(negedge clk); w++; end
      if (w >= 300) flag_fail($sformatf("x%0d.drain", XL));

      // Reset while the read strobe is up; a later memory response must be ignored.
      issue(0, 3'b010, 64'h40, 64'h0, 64'h0, 8);
      chk($sformatf("x%0d.access_strobe", XL), 64'(mrd), 64'h1);
      rst = 1'b0;
      expq.delete();
      @(negedge clk);
      chk($sformatf("x%0d.rst_mid_strobes", XL), {62'h0, mrd, mwr}, 64'h0);
      chk($sformatf("x%0d.rst_mid_ready", XL), 64'(req_ready), 64'h1);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      issue(0, 3'b010, 64'h10, 64'h0, 64'h1357_9BDF_8765_4321, 1);
      w = 0;
      while ((expq.size() != 0 || memq.size() != 0 || act) && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) flag_fail($sformatf("x%0d.drain_final", XL));
      done = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(gd[0].done && gd[1].done) && t < 60000) begin @(posedge clk); t++; end
    if (!(gd[0].done && gd[1].done)) begin
      n_chk++;
      n_fail++;
      $display("FAIL global_timeout: stimulus not complete after %0d cycles", t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
